ex_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage. It executes MULT, MULTU, DIV and DIVU over WIDTH-bit operands and returns a 2·WIDTH-bit {hi, lo} result. While it runs, it holds the pipeline through a stall request. It sits beside the EX ALU: EX drives the operands and start, and forwards the result toward the HI/LO write path when done pulses.

---
 rtl/ex_muldiv_pkg.sv | 24 ++
 rtl/ex_muldiv_unit.sv | 119 +++++++++++
 tb/tb_ex_muldiv_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - op encodings, FSM states and negate helper for ex_muldiv_unit
package ex_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } md_state_t;

  // Widest value the helper handles; callers zero-extend in and slice the low bits out.
  localparam int MD_MAX_W = 128;

  function automatic logic [MD_MAX_W-1:0] md_cond_neg(input logic [MD_MAX_W-1:0] v,
                                                      input logic neg);
    return neg ? (~v + MD_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with pipeline stall request
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  input  logic                 annul,
  output logic                 busy,
  output logic                 stallreq,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int XW = MD_MAX_W;

  md_state_t          state;
  logic               div_q;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] result_q;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     sum;
  logic               ge;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] fix_val;

  always_comb begin
    sign_a = ~op[0] & opa[WIDTH-1];
    sign_b = ~op[0] & opb[WIDTH-1];
    abs_a  = WIDTH'(md_cond_neg(XW'(opa), sign_a));
    abs_b  = WIDTH'(md_cond_neg(XW'(opb), sign_b));
  end

  // One shared adder: multiply adds the multiplicand into hi, divide trial-subtracts the divisor.
  always_comb begin
    add_a = div_q ? {1'b0, acc[2*WIDTH-2:WIDTH-1]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    sum   = div_q ? (add_a - {1'b0, addend}) : (add_a + {1'b0, addend});
    // A set top bit of the shifted remainder already exceeds any WIDTH-bit divisor.
    ge    = acc[2*WIDTH-1] | ~sum[WIDTH];
    if (div_q) begin
      acc_next = {(ge ? sum[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]), acc[WIDTH-2:0], ge};
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_comb begin
    quo_fix = WIDTH'(md_cond_neg(XW'(acc[WIDTH-1:0]), neg_q & ~b_zero));
    rem_fix = WIDTH'(md_cond_neg(XW'(acc[2*WIDTH-1:WIDTH]), neg_r));
    fix_val = div_q ? {rem_fix, quo_fix} : (2*WIDTH)'(md_cond_neg(XW'(acc), neg_q));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      cnt      <= '0;
      addend   <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (annul) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            div_q  <= op[1];
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            b_zero <= op[1] & (opb == '0);
            cnt    <= '0;
            addend <= op[1] ? abs_b : abs_a;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_val;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign stallreq = (start & (state == S_IDLE) & ~annul) | (state == S_RUN) | (state == S_FIX);
  assign result   = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit at WIDTH=32 and WIDTH=8
module tb_ex_muldiv_unit;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  always #5 clk = ~clk;

  logic        start, annul, busy, stallreq, done;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic [63:0] result;

  logic        start8, annul8, busy8, stallreq8, done8;
  logic [1:0]  op8;
  logic [7:0]  opa8, opb8;
  logic [15:0] result8;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .opa(opa), .opb(opb),
    .annul(annul), .busy(busy), .stallreq(stallreq), .done(done), .result(result)
  );

  ex_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .op(op8), .opa(opa8), .opb(opb8),
    .annul(annul8), .busy(busy8), .stallreq(stallreq8), .done(done8), .result(result8)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on w-bit operands, {rem, quo} or the 2w-bit product.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    logic [63:0] mw, m2w;
    longint ua, ub, sa, sb, q, r;
    mw  = (64'd1 << w) - 64'd1;
    m2w = (64'd1 << (2 * w)) - 64'd1;
    ua  = longint'({32'b0, a} & mw);
    ub  = longint'({32'b0, b} & mw);
    sa  = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb  = b[w-1] ? ub - (longint'(1) << w) : ub;
    if (o == MD_MULT)  return 64'(sa * sb) & m2w;
    if (o == MD_MULTU) return 64'(ua * ub) & m2w;
    if (ub == 0)       return ((64'(ua) << w) | mw) & m2w;
    if (o == MD_DIV) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return ((64'(r) & mw) << w) | (64'(q) & mw);
  endfunction

  task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] exp;
    int n;
    exp = ref_model(o, a, b, 32);
    op = o; opa = a; opb = b; start = 1'b1;
    #1 chk({tag, "_stall_req"}, 64'(stallreq), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_busy_run"}, 64'({busy, stallreq}), 64'b11);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_stall_done"}, 64'(stallreq), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, 64'({busy, done}), 64'b00);
  endtask

  task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] a,
                      input logic [7:0] b);
    logic [63:0] exp;
    int n;
    exp = ref_model(o, {24'b0, a}, {24'b0, b}, 8);
    op8 = o; opa8 = a; opb8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd9);
    chk({tag, "_result"}, {48'b0, result8}, exp);
    start8 = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, 64'({busy8, done8}), 64'b00);
  endtask

  initial begin
    logic [63:0] prev;
    logic        seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    start = 0; annul = 0; op = 0; opa = 0; opb = 0;
    start8 = 0; annul8 = 0; op8 = 0; opa8 = 0; opb8 = 0;

    @(posedge clk); #1;
    chk("reset_outputs", 64'({busy, done, stallreq, busy8, done8, stallreq8}), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_result8", {48'b0, result8}, 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    run32("mult_neg3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5);
    run32("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run32("divu_neg7_2", MD_DIVU, 32'hFFFF_FFF9, 32'd2);
    run32("divu_by_zero", MD_DIVU, 32'h0000_1234, 32'd0);
    run32("div_neg_by_zero", MD_DIV, 32'hFFFF_FF00, 32'd0);
    run32("div_overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run32("mult_minmin", MD_MULT, 32'h8000_0000, 32'h8000_0000);
    run32("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Annul mid-RUN: no done pulse, result untouched.
    prev = result;
    op = MD_MULTU; opa = 32'd6; opb = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul_idle", 64'({busy, stallreq}), 64'b00);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= done;
    end
    chk("annul_no_done", 64'(seen), 64'd0);
    chk("annul_result_kept", result, prev);
    run32("multu_6x7", MD_MULTU, 32'd6, 32'd7);

    // Annul together with start: the start is dropped.
    op = MD_MULT; opa = 32'd3; opb = 32'd3; start = 1'b1; annul = 1'b1;
    #1 chk("annul_start_stall", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    chk("annul_start_idle", 64'(busy), 64'd0);
    start = 1'b0; annul = 1'b0;

    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run32($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
    end

    run8("w8_multu_ff", MD_MULTU, 8'hFF, 8'hFF);
    chk("w8_multu_ff_const", {48'b0, result8}, 64'h0000_0000_0000_FE01);
    run8("w8_div_80_ff", MD_DIV, 8'h80, 8'hFF);
    chk("w8_div_80_ff_const", {48'b0, result8}, 64'h0000_0000_0000_0080);
    for (int i = 0; i < 6; i++) begin
      run8($sformatf("w8_rand%0d", i), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end

    // Reset mid-RUN: outputs drop asynchronously.
    op = MD_DIV; opa = 32'h1234_5678; opb = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'({busy, done, stallreq}), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_idle", 64'({busy, done, stallreq}), 64'd0);
    chk("rst_release_result", result, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
